i2c_simple_master_controller: RTL and testbench

//  Bus master for the 3-data-line simple I2C link (sda1/sda2/sda3 + scl). Accepts one command
//  (data UB/LB, rw_sel, slave addr, burst sel/len, 20-bit initial addr) via valid/ready.

---
 rtl/i2c_simple_master_controller.sv | 207 ++++++++++++++++++++
 tb/tb_i2c_simple_master_controller.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_simple_master_controller.sv
// i2c_simple_master_controller
// Master for the three-data-line simple I2C link. One command is latched
// when cmd_valid meets cmd_ready. The block then sends START, a 20-bit
// parallel frame on sda1/sda2/sda3, one ACK clock slot and STOP.
// Every bus phase lasts CLK_DIV clocks, and all bus outputs are registered.

module i2c_simple_master_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_ub,
  input  logic [7:0]  cmd_lb,
  input  logic [2:0]  cmd_rw_sel,
  input  logic [4:0]  cmd_slave,
  input  logic        cmd_burst_sel,
  input  logic [6:0]  cmd_burst_len,
  input  logic [19:0] cmd_addr,
  output logic        busy,
  output logic        done,
  output logic        scl,
  output logic        sda1,
  output logic        sda2,
  output logic        sda3
);

  localparam int             PW         = $clog2(CLK_DIV);
  localparam logic [PW-1:0]  PHASE_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0]  PHASE_ZERO = {PW{1'b0}};
  localparam logic [4:0]     BIT_FIRST  = 5'd19;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_START    = 4'd1,
    S_BIT_LO   = 4'd2,
    S_BIT_HI   = 4'd3,
    S_ACK_LO   = 4'd4,
    S_ACK_HI   = 4'd5,
    S_STOP_LO  = 4'd6,
    S_STOP_HI  = 4'd7,
    S_STOP_REL = 4'd8
  } state_t;

  state_t        state_r, state_s;
  logic [PW-1:0] phase_r, phase_s;
  logic [4:0]    bit_r, bit_s;
  logic [19:0]   frame1_r, frame2_r, frame3_r;
  logic          accept_s, phase_end_s, done_s;
  logic          scl_s, sda1_s, sda2_s, sda3_s;
  logic          scl_r, sda1_r, sda2_r, sda3_r;
  logic          busy_r, done_r, ready_r;

  assign cmd_ready = ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign scl       = scl_r;
  assign sda1      = sda1_r;
  assign sda2      = sda2_r;
  assign sda3      = sda3_r;

  assign accept_s    = cmd_valid && (state_r == S_IDLE);
  assign phase_end_s = (phase_r == PHASE_ZERO);

  // Next-state logic: phase down-counter, bit index and bus state sequencing
  always_comb begin
    state_s = state_r;
    phase_s = phase_r;
    bit_s   = bit_r;
    done_s  = 1'b0;
    if (state_r == S_IDLE) begin
      if (accept_s) begin
        state_s = S_START;
        phase_s = PHASE_LAST;
        bit_s   = BIT_FIRST;
      end else begin
        phase_s = PHASE_ZERO;
      end
    end else if (!phase_end_s) begin
      phase_s = phase_r - PW'(1);
    end else begin
      phase_s = PHASE_LAST;
      case (state_r)
        S_START:   state_s = S_BIT_LO;
        S_BIT_LO:  state_s = S_BIT_HI;
        S_BIT_HI: begin
          if (bit_r == 5'd0) begin
            state_s = S_ACK_LO;
          end else begin
            bit_s   = bit_r - 5'd1;
            state_s = S_BIT_LO;
          end
        end
        S_ACK_LO:  state_s = S_ACK_HI;
        S_ACK_HI:  state_s = S_STOP_LO;
        S_STOP_LO: state_s = S_STOP_HI;
        S_STOP_HI: state_s = S_STOP_REL;
        S_STOP_REL: begin
          state_s = S_IDLE;
          phase_s = PHASE_ZERO;
          done_s  = 1'b1;
        end
        default: begin
          state_s = S_IDLE;
          phase_s = PHASE_ZERO;
        end
      endcase
    end
  end

  // Bus line values for the state being entered, so the registered lines change exactly at phase starts
  always_comb begin
    scl_s  = 1'b1;
    sda1_s = 1'b1;
    sda2_s = 1'b1;
    sda3_s = 1'b1;
    case (state_s)
      S_IDLE: begin
        scl_s = 1'b1;
      end
      S_START: begin
        sda3_s = 1'b0;
      end
      S_BIT_LO: begin
        scl_s  = 1'b0;
        sda1_s = frame1_r[bit_s];
        sda2_s = frame2_r[bit_s];
        sda3_s = frame3_r[bit_s];
      end
      S_BIT_HI: begin
        sda1_s = frame1_r[bit_s];
        sda2_s = frame2_r[bit_s];
        sda3_s = frame3_r[bit_s];
      end
      S_ACK_LO, S_STOP_LO: begin
        scl_s  = 1'b0;
        sda1_s = 1'b0;
        sda2_s = 1'b0;
        sda3_s = 1'b0;
      end
      S_ACK_HI, S_STOP_HI: begin
        sda1_s = 1'b0;
        sda2_s = 1'b0;
        sda3_s = 1'b0;
      end
      S_STOP_REL: begin
        scl_s = 1'b1;
      end
      default: begin
        scl_s = 1'b1;
      end
    endcase
  end

  // State, counters and handshake/status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      phase_r <= PHASE_ZERO;
      bit_r   <= 5'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_s;
      phase_r <= phase_s;
      bit_r   <= bit_s;
      busy_r  <= (state_s != S_IDLE);
      done_r  <= done_s;
      ready_r <= (state_s == S_IDLE);
    end
  end

  // Capture the three line frames once, at command acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      frame1_r <= 20'd0;
      frame2_r <= 20'd0;
      frame3_r <= 20'd0;
    end else if (accept_s) begin
      frame1_r <= {cmd_ub, cmd_rw_sel, cmd_slave, 4'b0000};
      frame2_r <= {cmd_lb, cmd_burst_sel, cmd_burst_len, 4'b0000};
      frame3_r <= cmd_addr;
    end else begin
      frame1_r <= frame1_r;
      frame2_r <= frame2_r;
      frame3_r <= frame3_r;
    end
  end

  // Registered bus lines; reset releases everything high on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_r  <= 1'b1;
      sda1_r <= 1'b1;
      sda2_r <= 1'b1;
      sda3_r <= 1'b1;
    end else begin
      scl_r  <= scl_s;
      sda1_r <= sda1_s;
      sda2_r <= sda2_s;
      sda3_r <= sda3_s;
    end
  end

endmodule

// File: tb/tb_i2c_simple_master_controller.sv
// Testbench for i2c_simple_master_controller with two instances (CLK_DIV=4 and 2).
// Stimulus pushes the expected frames into a scoreboard queue. A bus monitor
// decodes the lines on rising scl and checks each frame at STOP.

module tb_i2c_simple_master_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input int cd, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (CLK_DIV=%0d): got %0h expected %0h", nm, cd, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int CD = (g == 0) ? 4 : 2;

    logic        rst, cmd_valid, cmd_ready, bs, busy, done, scl, sda1, sda2, sda3;
    logic [7:0]  ub, lb;
    logic [2:0]  rw;
    logic [4:0]  sl;
    logic [6:0]  bl;
    logic [19:0] ad;
    bit          fin_l = 1'b0;

    i2c_simple_master_controller #(.CLK_DIV(CD)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_ub(ub), .cmd_lb(lb), .cmd_rw_sel(rw), .cmd_slave(sl),
      .cmd_burst_sel(bs), .cmd_burst_len(bl), .cmd_addr(ad),
      .busy(busy), .done(done), .scl(scl), .sda1(sda1), .sda2(sda2), .sda3(sda3)
    );

    logic [59:0] exp_q[$];
    int          acc_q[$];
    int          cyc = 0;
    int          n_done = 0;
    logic        p_scl = 1'b1, p1 = 1'b1, p2 = 1'b1, p3 = 1'b1;
    int          rise = 0;
    int          hi_run = 0;
    bit          in_frame = 1'b0;
    logic [19:0] f1, f2, f3;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor and scoreboard
    always @(negedge clk) begin
      if (rst) begin
        in_frame = 1'b0;
        acc_q.delete();
      end else begin
        if (cmd_valid && cmd_ready) acc_q.push_back(cyc + 1);
        if (done) begin
          n_done++;
          chk("done_pending", CD, acc_q.size() > 0, 1'b1);
          if (acc_q.size() > 0) chk("done_latency", CD, cyc - acc_q.pop_front(), 46 * CD);
        end
        if (p_scl && scl) begin
          if (p3 && !sda3 && sda1 == p1 && sda2 == p2 && !in_frame) begin
            chk("start_idle_high", CD, hi_run >= CD, 1'b1);
            in_frame = 1'b1;
            rise = 0;
          end else if (!p3 && sda3 && in_frame) begin
            chk("stop_release", CD, {sda1, sda2}, 2'b11);
            chk("rise_count", CD, rise, 22);
            chk("frame_expected", CD, exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) chk("frame", CD, {f1, f2, f3}, exp_q.pop_front());
            in_frame = 1'b0;
          end else if ({sda1, sda2, sda3} != {p1, p2, p3}) begin
            chk("sda_stable_scl_high", CD, {sda1, sda2, sda3}, {p1, p2, p3});
          end
        end else if (!p_scl && scl && in_frame) begin
          rise++;
          if (rise <= 20) begin
            f1 = {f1[18:0], sda1};
            f2 = {f2[18:0], sda2};
            f3 = {f3[18:0], sda3};
          end else if (rise == 21) begin
            chk("ack_slot_low", CD, {sda1, sda2, sda3}, 3'b000);
          end
        end
      end
      hi_run = (scl && sda3) ? hi_run + 1 : 0;
      p_scl = scl;
      p1 = sda1;
      p2 = sda2;
      p3 = sda3;
    end

    task automatic load(input logic [7:0] u, input logic [7:0] l, input logic [2:0] r,
                        input logic [4:0] s, input logic b, input logic [6:0] n, input logic [19:0] a);
      ub = u; lb = l; rw = r; sl = s; bs = b; bl = n; ad = a;
    endtask

    task automatic wait_accept(output logic was_done);
      bit got = 1'b0;
      was_done = 1'b0;
      for (int i = 0; i < 400 && !got; i++) begin
        @(negedge clk);
        if (cmd_ready) begin
          got = 1'b1;
          was_done = done;
        end
      end
      chk("accept_seen", CD, got, 1'b1);
      @(posedge clk);
      #1;
    endtask

    task automatic wait_done();
      bit got = 1'b0;
      for (int i = 0; i < 500 && !got; i++) begin
        @(negedge clk);
        if (done) got = 1'b1;
      end
      chk("done_seen", CD, got, 1'b1);
      chk("ready_at_done", CD, cmd_ready, 1'b1);
      chk("busy_at_done", CD, busy, 1'b0);
    endtask

    // Directed stimulus
    initial begin
      logic wd;
      rst = 1'b1;
      cmd_valid = 1'b0;
      load(8'h00, 8'h00, 3'b000, 5'h00, 1'b0, 7'h00, 20'h00000);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_lines", CD, {scl, sda1, sda2, sda3}, 4'hF);
      chk("reset_busy", CD, busy, 1'b0);
      chk("reset_ready", CD, cmd_ready, 1'b0);
      chk("reset_done", CD, done, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("ready_after_reset", CD, cmd_ready, 1'b1);
      repeat (6) @(posedge clk);
      #1;

      // Back-to-back: A then B with cmd_valid held
      exp_q.push_back({20'hA53F0, 20'h3CD50, 20'hABCDE});
      load(8'hA5, 8'h3C, 3'b001, 5'h1F, 1'b1, 7'h55, 20'hABCDE);
      cmd_valid = 1'b1;
      wait_accept(wd);
      exp_q.push_back({20'h5ACA0, 20'hC32A0, 20'h12345});
      load(8'h5A, 8'hC3, 3'b110, 5'h0A, 1'b0, 7'h2A, 20'h12345);
      wait_accept(wd);
      chk("b2b_in_done_cycle", CD, wd, 1'b1);
      cmd_valid = 1'b0;

      // Busy ignore: junk command pulsed mid-frame
      repeat (15 * CD) @(posedge clk);
      #1;
      load(8'hFF, 8'hFF, 3'b111, 5'h00, 1'b1, 7'h7F, 20'hFFFFF);
      cmd_valid = 1'b1;
      @(negedge clk);
      chk("busy_mid_frame", CD, busy, 1'b1);
      chk("ready_mid_frame", CD, cmd_ready, 1'b0);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      wait_done();
      repeat (5) @(posedge clk);
      #1;

      // Abort during BIT_HI(10)
      load(8'hA5, 8'h3C, 3'b001, 5'h1F, 1'b1, 7'h55, 20'hABCDE);
      cmd_valid = 1'b1;
      wait_accept(wd);
      cmd_valid = 1'b0;
      repeat (20 * CD) @(posedge clk);
      @(negedge clk);
      chk("pre_abort_scl", CD, scl, 1'b1);
      chk("pre_abort_sda3", CD, sda3, 1'b1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort_lines", CD, {scl, sda1, sda2, sda3}, 4'hF);
      chk("abort_busy", CD, busy, 1'b0);
      chk("abort_done", CD, done, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;

      // Fresh command after abort
      exp_q.push_back({20'h81550, 20'h7E010, 20'h80001});
      load(8'h81, 8'h7E, 3'b010, 5'h15, 1'b0, 7'h01, 20'h80001);
      cmd_valid = 1'b1;
      wait_accept(wd);
      cmd_valid = 1'b0;
      wait_done();
      repeat (10) @(posedge clk);
      chk("done_count", CD, n_done, 3);
      chk("scoreboard_empty", CD, exp_q.size(), 0);
      fin_l = 1'b1;
    end
  end

  // Completion and summary
  initial begin
    for (int t = 0; t < 30000 && !(inst[0].fin_l && inst[1].fin_l); t++) @(posedge clk);
    chk("finished", 0, {inst[0].fin_l, inst[1].fin_l}, 2'b11);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
